// File: rtl/rfsoc_cap_pkg.sv
// Shared types and constants for the RFSoC capture path (ADC capture and BRAM copy engine).
package rfsoc_cap_pkg;

  localparam int unsigned BRAM_STEP           = 4;
  localparam int unsigned CAP_MAXADDR_DEFAULT = 32'd8192;
  localparam int unsigned ADC_DATA_W          = 32;
  localparam int unsigned ADC_LANE_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // One RFDC beat: lane 0 in the low half is the trigger lane
  typedef struct packed {
    logic [ADC_LANE_W-1:0] lane1;
    logic [ADC_LANE_W-1:0] lane0;
  } adc_beat_t;

  function automatic int unsigned cap_words(input int unsigned maxaddr);
    return maxaddr / BRAM_STEP;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchroniser for an asynchronous level, with a rising-edge strobe.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d};
    end
  end

  // Edge taken between the second and third stages, both already metastability-safe
  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_capture_bram.sv
// Arms on a PS request, triggers on the ADC stream and fills the source BRAM with one
// fixed-size capture, then raises a stretched completion pulse for the copy engine.
module adc_capture_bram
  import rfsoc_cap_pkg::*;
#(
  parameter int unsigned MAXADDR   = CAP_MAXADDR_DEFAULT,
  parameter int unsigned TRIG_HOLD = 8,
  localparam int unsigned WC_W     = $clog2(MAXADDR / BRAM_STEP) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic [15:0]       threshold,
  input  logic [31:0]       adc_tdata,
  input  logic              adc_tvalid,
  output logic [31:0]       bram_addr,
  output logic [31:0]       bram_din,
  output logic              bram_en,
  output logic              bram_we,
  output logic              busy,
  output logic              capture_done,
  output logic              capture_trig,
  output logic [WC_W-1:0]   word_count
);

  localparam int unsigned WORDS  = cap_words(MAXADDR);
  localparam int unsigned HOLD_W = (TRIG_HOLD > 2) ? $clog2(TRIG_HOLD) : 1;

  cap_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       addr_d, din_d;
  logic [WC_W-1:0]   wc_d;
  logic              we_d, trig_d;
  logic              arm_rise_c, trig_hit_c, accept_c, arm_start_c;
  adc_beat_t         beat_c;

  sync_edge_detect u_arm_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (arm),
    .rise_c (arm_rise_c)
  );

  assign beat_c     = adc_beat_t'(adc_tdata);
  assign trig_hit_c = adc_tvalid &&
                      (!trig_mode || ($signed(beat_c.lane0) > $signed(threshold)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, write path and completion pulse
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    arm_start_c = 1'b0;
    addr_d      = bram_addr;
    din_d       = bram_din;
    we_d        = 1'b0;
    wc_d        = word_count;
    trig_d      = capture_trig;
    hold_d      = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_rise_c) begin
          state_d     = ST_ARMED;
          arm_start_c = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_hit_c) begin
          accept_c = 1'b1;
          state_d  = (WORDS == 1) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (adc_tvalid) begin
          accept_c = 1'b1;
          if (word_count == WC_W'(WORDS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (arm_rise_c) begin
          state_d     = ST_ARMED;
          arm_start_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arm_start_c) begin
      addr_d = 32'd0;
      wc_d   = '0;
    end

    // The trigger beat is word 0; later beats step the address, which never wraps
    if (accept_c) begin
      we_d   = 1'b1;
      din_d  = adc_tdata;
      addr_d = (word_count == '0) ? 32'd0 : bram_addr + 32'(BRAM_STEP);
      wc_d   = word_count + WC_W'(1);
    end

    if (state_d == ST_DONE && state_q != ST_DONE) begin
      trig_d = 1'b1;
      hold_d = HOLD_W'(TRIG_HOLD - 1);
    end else if (state_d != ST_DONE) begin
      trig_d = 1'b0;
      hold_d = '0;
    end else if (capture_trig) begin
      if (hold_q == '0) begin
        trig_d = 1'b0;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr    <= 32'd0;
      bram_din     <= 32'd0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      capture_trig <= 1'b0;
      word_count   <= '0;
      hold_q       <= '0;
    end else begin
      bram_addr    <= addr_d;
      bram_din     <= din_d;
      bram_en      <= 1'b1;
      bram_we      <= we_d;
      busy         <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
      capture_done <= (state_d == ST_DONE);
      capture_trig <= trig_d;
      word_count   <= wc_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_bram.sv
// Directed bench for adc_capture_bram: immediate, threshold, gappy valid, re-arm and reset cases.
module tb_adc_capture_bram;

  localparam int unsigned MAXADDR   = 8192;
  localparam int unsigned WORDS     = MAXADDR / 4;
  localparam int unsigned TRIG_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        trig_mode;
  logic [15:0] threshold;
  logic [31:0] adc_tdata;
  logic        adc_tvalid;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic        bram_en;
  logic        bram_we;
  logic        busy;
  logic        capture_done;
  logic        capture_trig;
  logic [11:0] word_count;

  int total = 0;
  int bad   = 0;
  int trig_edges = 0;
  logic trig_prev = 1'b0;

  adc_capture_bram #(.MAXADDR(MAXADDR), .TRIG_HOLD(TRIG_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .trig_mode    (trig_mode),
    .threshold    (threshold),
    .adc_tdata    (adc_tdata),
    .adc_tvalid   (adc_tvalid),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .busy         (busy),
    .capture_done (capture_done),
    .capture_trig (capture_trig),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  // Downstream view: count rising edges of the completion pulse
  always @(negedge clk) begin
    if (capture_trig && !trig_prev) trig_edges++;
    trig_prev = capture_trig;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, bram_addr, 32'd0);
    chk({tag, "_din"},  bram_din, 32'd0);
    chk({tag, "_en"},   32'(bram_en), 32'd0);
    chk({tag, "_we"},   32'(bram_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(capture_done), 32'd0);
    chk({tag, "_trig"}, 32'(capture_trig), 32'd0);
    chk({tag, "_wc"},   32'(word_count), 32'd0);
  endtask

  task automatic do_arm();
    int n;
    n = 0;
    adc_tvalid = 1'b0;
    arm = 1'b1;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_latency", 32'(n), 32'd3);
    arm = 1'b0;
    chk("arm_wc", 32'(word_count), 32'd0);
    chk("arm_addr", bram_addr, 32'd0);
    chk("arm_done", 32'(capture_done), 32'd0);
    chk("arm_trig", 32'(capture_trig), 32'd0);
  endtask

  // Streams beats (continuous or 1-0-0 pattern) and checks every write until DONE
  task automatic run_capture(input bit gappy, input int arm_at);
    int   cyc;
    int   nwr;
    logic v;
    cyc = 0;
    nwr = 0;
    while (nwr < WORDS && cyc < 8000) begin
      v = gappy ? (cyc % 3 == 0) : 1'b1;
      if (cyc == arm_at) arm = 1'b1;
      if (cyc == arm_at + 6) arm = 1'b0;
      adc_tvalid = v;
      adc_tdata  = 32'(nwr);
      tick();
      chk("we_strobe", 32'(bram_we), 32'(v));
      if (v) begin
        chk("wr_addr", bram_addr, 32'(nwr * 4));
        chk("wr_din", bram_din, 32'(nwr));
        nwr++;
        chk("wr_count", 32'(word_count), 32'(nwr));
      end
      cyc++;
    end
    chk("write_total", 32'(nwr), 32'(WORDS));
    chk("entry_done", 32'(capture_done), 32'd1);
    chk("entry_trig", 32'(capture_trig), 32'd1);
    chk("entry_busy", 32'(busy), 32'd0);
    chk("entry_addr", bram_addr, 32'(MAXADDR - 4));
  endtask

  // Called right after DONE entry; valid beats in DONE must not write
  task automatic check_hold();
    int highs;
    highs = 1;
    for (int i = 0; i < 12; i++) begin
      adc_tvalid = 1'b1;
      adc_tdata  = 32'hDEAD0000 + 32'(i);
      tick();
      if (capture_trig) highs++;
      chk("done_no_write", 32'(bram_we), 32'd0);
    end
    chk("trig_hold", 32'(highs), 32'(TRIG_HOLD));
    chk("hold_done", 32'(capture_done), 32'd1);
    chk("hold_wc", 32'(word_count), 32'(WORDS));
    chk("hold_addr", bram_addr, 32'(MAXADDR - 4));
    chk("hold_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int i;
    rst_n      = 1'b0;
    arm        = 1'b0;
    trig_mode  = 1'b0;
    threshold  = 16'd0;
    adc_tdata  = 32'd0;
    adc_tvalid = 1'b0;

    // Reset values
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_en", 32'(bram_en), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_wc", 32'(word_count), 32'd0);

    // Triggering beats while IDLE do nothing
    for (int k = 0; k < 5; k++) begin
      adc_tvalid = 1'b1;
      adc_tdata  = 32'(k);
      tick();
      chk("idle_no_write", 32'(bram_we), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Immediate mode, continuous valid
    do_arm();
    run_capture(1'b0, -1);
    check_hold();

    // Gappy valid with an ignored arm edge mid-capture
    do_arm();
    run_capture(1'b1, 200);
    check_hold();

    // Re-arm in DONE at hold cycle 3
    do_arm();
    run_capture(1'b0, -1);
    adc_tvalid = 1'b0;
    arm = 1'b1;
    tick();
    chk("rearm_trig_h1", 32'(capture_trig), 32'd1);
    tick();
    chk("rearm_trig_h2", 32'(capture_trig), 32'd1);
    tick();
    chk("rearm_trig_drop", 32'(capture_trig), 32'd0);
    chk("rearm_done_clr", 32'(capture_done), 32'd0);
    chk("rearm_wc_clr", 32'(word_count), 32'd0);
    chk("rearm_busy", 32'(busy), 32'd1);
    chk("rearm_addr", bram_addr, 32'd0);
    arm = 1'b0;
    run_capture(1'b0, -1);
    check_hold();

    // Threshold mode: lane 0 ramps from -50, strict compare against 100
    trig_mode = 1'b1;
    threshold = 16'd100;
    do_arm();
    i = 0;
    while (i < 151) begin
      adc_tvalid = 1'b1;
      adc_tdata  = {16'h1234, 16'(-50 + i)};
      tick();
      chk("thr_wait", 32'(bram_we), 32'd0);
      i++;
    end
    adc_tdata = {16'h1234, 16'(-50 + i)};
    tick();
    chk("thr_first_we", 32'(bram_we), 32'd1);
    chk("thr_first_din", bram_din, 32'h12340065);
    chk("thr_first_addr", bram_addr, 32'd0);
    chk("thr_first_wc", 32'(word_count), 32'd1);
    i++;
    adc_tdata = {16'h1234, 16'(-50 + i)};
    tick();
    chk("thr_second_din", bram_din, 32'h12340066);
    chk("thr_second_addr", bram_addr, 32'd4);
    i++;
    while (word_count != 12'd500 && i < 800) begin
      adc_tdata = {16'h1234, 16'(-50 + i)};
      tick();
      i++;
    end
    chk("thr_reach_500", 32'(word_count), 32'd500);
    chk("thr_busy", 32'(busy), 32'd1);

    // Asynchronous reset between edges at word 500
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    trig_mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      adc_tvalid = 1'b1;
      adc_tdata  = 32'(k);
      tick();
      chk("after_reset_no_write", 32'(bram_we), 32'd0);
      chk("after_reset_busy", 32'(busy), 32'd0);
    end
    chk("after_reset_en", 32'(bram_en), 32'd1);
    chk("after_reset_done", 32'(capture_done), 32'd0);

    // One completion edge per finished capture; the aborted one gives none
    chk("trig_edges", 32'(trig_edges), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
